// File: rtl/mem_pkg.sv
// Shared types for the memory port arbiter: access size codes, arbiter states, owner tag.
// No logic state; mode_legal() is purely combinational.
// Not applicable (no handshake in a package).
package mem_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2,
    ERR_ACK = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Unsigned sizes only make sense for loads; undefined funct3 codes are never legal.
  function automatic logic mode_legal(input logic [2:0] mode, input logic wen);
    case (mode)
      MEM_B, MEM_H, MEM_W: mode_legal = 1'b1;
      MEM_BU, MEM_HU:      mode_legal = !wen;
      default:             mode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Requester (IF, D) and memory-side signals of the shared RV32I memory port.
// Wires only; timing is defined by the arbiter.
// Requesters hold req until ack; memory holds nothing, arbiter holds m_* until m_ack.
interface mem_port_arb_if #(
  parameter int AW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic          if_err;
  logic [31:0]   if_rdata;

  logic          d_req;
  logic          d_wen;
  logic [2:0]    d_mode;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ack;
  logic          d_err;
  logic [31:0]   d_rdata;

  logic          m_req;
  logic          m_wen;
  logic [2:0]    m_mode;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic          m_ack;
  logic [31:0]   m_rdata;

  logic          proto_err;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, d_req, d_wen, d_mode, d_addr, d_wdata, m_ack, m_rdata,
    output if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
    output m_req, m_wen, m_mode, m_addr, m_wdata, proto_err
  );

  // Requester/memory (environment) view.
  modport master (
    output if_req, if_addr, d_req, d_wen, d_mode, d_addr, d_wdata, m_ack, m_rdata,
    input  if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
    input  m_req, m_wen, m_mode, m_addr, m_wdata, proto_err
  );
endinterface

// File: rtl/mem_align_chk.sv
// Flags an access whose size code is illegal or whose address is not naturally aligned.
// Purely combinational, zero latency.
// No handshake.
module mem_align_chk
  import mem_pkg::*;
(
  input  logic [1:0] addr_i,
  input  logic [2:0] mode_i,
  input  logic       wen_i,
  output logic       misaligned_o
);

  // Illegal mode first, then natural-alignment rules for halfword and word sizes.
  always_comb begin
    misaligned_o = !mode_legal(mode_i, wen_i);
    case (mode_i)
      MEM_H, MEM_HU: if (addr_i[0])        misaligned_o = 1'b1;
      MEM_W:         if (addr_i != 2'b00)  misaligned_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arb.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time.
// 1 arbitration cycle + 1 m_req cycle minimum; each memory wait cycle adds one; misaligned answered in 2.
// Requesters stall (hold req) until their ack; m_* held stable until m_ack.
module mem_port_arb
  import mem_pkg::*;
#(
  parameter int MAX_D_BURST = 4,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_port_arb_if.slave bus
);

  localparam int            BW        = $clog2(MAX_D_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);

  arb_state_t    state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          m_req_q, m_req_d;
  logic          m_wen_q, m_wen_d;
  logic [2:0]    m_mode_q, m_mode_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [31:0]   m_wdata_q, m_wdata_d;
  logic          proto_err_q, proto_err_d;
  logic          if_mis, d_mis;
  logic          d_win, if_win;

  // Fetches are always word reads.
  mem_align_chk u_if_chk (
    .addr_i       (bus.if_addr[1:0]),
    .mode_i       (MEM_W),
    .wen_i        (1'b0),
    .misaligned_o (if_mis)
  );

  mem_align_chk u_d_chk (
    .addr_i       (bus.d_addr[1:0]),
    .mode_i       (bus.d_mode),
    .wen_i        (bus.d_wen),
    .misaligned_o (d_mis)
  );

  assign bus.m_req     = m_req_q;
  assign bus.m_wen     = m_wen_q;
  assign bus.m_mode    = m_mode_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.proto_err = proto_err_q;

  // Arbitration, memory command loading and owner responses.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_d     = burst_q;
    m_req_d     = m_req_q;
    m_wen_d     = m_wen_q;
    m_mode_d    = m_mode_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    // An ack from memory with nothing outstanding is a protocol violation; remember it.
    proto_err_d = proto_err_q | (bus.m_ack && (state_q != IF_BUSY) && (state_q != D_BUSY));
    d_win       = 1'b0;
    if_win      = 1'b0;
    bus.if_ack   = 1'b0;
    bus.if_err   = 1'b0;
    bus.if_rdata = '0;
    bus.d_ack    = 1'b0;
    bus.d_err    = 1'b0;
    bus.d_rdata  = '0;

    case (state_q)
      IDLE: begin
        // Data wins unless fetch has been starved for MAX_D_BURST data grants.
        d_win  = bus.d_req && !(bus.if_req && (burst_q == BURST_MAX));
        if_win = bus.if_req && !d_win;
        if (!bus.if_req) burst_d = '0;
        if (d_win) begin
          owner_d = OWN_D;
          if (bus.if_req && (burst_q != BURST_MAX)) burst_d = burst_q + 1'b1;
          if (d_mis) begin
            state_d = ERR_ACK;
          end else begin
            state_d   = D_BUSY;
            m_req_d   = 1'b1;
            m_wen_d   = bus.d_wen;
            m_mode_d  = bus.d_mode;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
          end
        end else if (if_win) begin
          owner_d = OWN_IF;
          burst_d = '0;
          if (if_mis) begin
            state_d = ERR_ACK;
          end else begin
            state_d   = IF_BUSY;
            m_req_d   = 1'b1;
            m_wen_d   = 1'b0;
            m_mode_d  = MEM_W;
            m_addr_d  = bus.if_addr;
            m_wdata_d = '0;
          end
        end
      end
      IF_BUSY: begin
        if (bus.m_ack) begin
          bus.if_ack   = 1'b1;
          bus.if_rdata = bus.m_rdata;
          m_req_d      = 1'b0;
          state_d      = IDLE;
        end
      end
      D_BUSY: begin
        if (bus.m_ack) begin
          bus.d_ack   = 1'b1;
          bus.d_rdata = bus.m_rdata;
          m_req_d     = 1'b0;
          state_d     = IDLE;
        end
      end
      ERR_ACK: begin
        if (owner_q == OWN_D) begin
          bus.d_ack = 1'b1;
          bus.d_err = 1'b1;
        end else begin
          bus.if_ack = 1'b1;
          bus.if_err = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered memory command; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      burst_q     <= '0;
      m_req_q     <= 1'b0;
      m_wen_q     <= 1'b0;
      m_mode_q    <= 3'b000;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      m_req_q     <= m_req_d;
      m_wen_q     <= m_wen_d;
      m_mode_q    <= m_mode_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Sequences and shares the single RV32I memory port between two requesters: instruction fetch (IF) and data load/store (D).
- Lets the control unit issue fetch and load/store as separate transactions on one memory, with stalls, instead of needing a second RAM port.
- Sits between the control unit and the memory; exactly one transaction is outstanding at a time.
- Checks alignment and answers misaligned requests itself, without touching memory.

Parameters:
- MAX_D_BURST, 4: maximum consecutive D grants while if_req is pending before IF is forced.
- AW, 32: address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  AW  fetch address; always word mode
- if_ack  out  1  fetch done (1-cycle pulse)
- if_err  out  1  fetch misaligned; valid with if_ack
- if_rdata  out  32  fetched word; valid with if_ack
- d_req  in  1  data request; held with d_* until d_ack
- d_wen  in  1  1 = store, 0 = load
- d_mode  in  3  funct3 size code (mem_mode_t)
- d_addr  in  AW  data address
- d_wdata  in  32  store data
- d_ack  out  1  data done (1-cycle pulse)
- d_err  out  1  data misaligned or illegal mode; valid with d_ack
- d_rdata  out  32  load data; valid with d_ack
- m_req  out  1  memory request (registered)
- m_wen  out  1  memory write enable (registered)
- m_mode  out  3  memory size mode (registered)
- m_addr  out  AW  memory address (registered)
- m_wdata  out  32  memory write data (registered)
- m_ack  in  1  memory completion; may assert in the first m_req cycle
- m_rdata  in  32  memory read data; valid with m_ack
- proto_err  out  1  sticky: m_ack seen while not in IF_BUSY or D_BUSY

Behaviour:
- Reset: state = IDLE, burst counter = 0, proto_err = 0, all m_* = 0.
- Reset: if_ack, d_ack, if_err and d_err read 0 in the cycle after the reset edge.
- Reset mid-transaction abandons the transaction; the memory shares rst.
- States: IDLE, IF_BUSY, D_BUSY, ERR_ACK. ERR_ACK also records the owner of the failed request.
- IDLE, arbitration uses the requests sampled this cycle:
  - D wins over IF.
  - Exception: IF wins when if_req=1 and burst counter == MAX_D_BURST.
- IDLE, granted request is aligned and legal: next state IF_BUSY or D_BUSY.
  - m_req=1 and m_addr/m_wen/m_mode/m_wdata are loaded from the winner on the same edge.
  - For IF: m_wen=0, m_mode=MEM_W.
- IDLE, granted request is misaligned: next state ERR_ACK; m_req stays 0.
- Misaligned means:
  - MEM_H or MEM_HU with addr[0]=1.
  - MEM_W with addr[1:0]!=0.
  - d_mode not in {0,1,2,4,5}.
  - IF with if_addr[1:0]!=0.
- Stores with MEM_BU or MEM_HU are illegal and take the misaligned path.
- IF_BUSY / D_BUSY:
  - m_* held stable until m_ack.
  - In the m_ack cycle the owner's ack = 1 combinationally and owner rdata = m_rdata; the other requester's ack = 0.
  - On that edge: m_req → 0, state → IDLE.
- ERR_ACK: owner's ack = 1 and err = 1 for one cycle, rdata = 0, then IDLE.
- Minimum access is 2 cycles: one arbitration cycle plus one m_req cycle. Each extra memory wait cycle adds one.
- The requester may change or drop req on the edge after its ack. A still-high req is treated as a new request.
- Burst counter:
  - +1 on each D grant while if_req=1, saturating at MAX_D_BURST.
  - Cleared on an IF grant, or in any IDLE cycle with if_req=0.
- A D grant with if_req=0 leaves the counter at 0.
- proto_err is sticky until rst. A stray m_ack is otherwise ignored.
- if_rdata and d_rdata are 0 whenever their ack is 0.

Decomposition:
- Package mem_pkg:
  - mem_mode_t enum: MEM_B=3'b000, MEM_H=3'b001, MEM_W=3'b010, MEM_BU=3'b100, MEM_HU=3'b101.
  - arb_state_t enum.
  - Function mode_legal(mode, wen).
- Sub-module mem_align_chk: combinational; inputs addr[1:0], mode, wen; output misaligned.
  - Instantiated twice: IF with mode fixed MEM_W and wen=0, and D.

Test Plan:
- IF only, if_addr=0x10, memory acks in the first m_req cycle with 0x00500093:
  - m_req high exactly 1 cycle with m_addr=0x10, m_mode=2.
  - if_ack pulses with if_rdata=0x00500093; 2 cycles total.
- if_req and d_req rise together, d_wen=1, d_addr=0x20, d_wdata=0xDEADBEEF, d_mode=2:
  - D served first: m_wen=1, m_addr=0x20.
  - IF served next; d_ack precedes if_ack.
- D: MEM_H at 0x21, MEM_W at 0x22, store MEM_BU at 0x20, mode 3 at 0x20:
  - Each gives d_ack=1, d_err=1, and m_req never asserts.
- d_req and if_req both held high continuously with 2-cycle memory latency, MAX_D_BURST=4:
  - Grant order D,D,D,D,IF,D,D,D,D,IF.
- Reset asserted during D_BUSY with m_ack withheld:
  - Next cycle m_req=0, all acks 0, state IDLE.
  - A subsequent IF completes normally.
- m_ack pulsed while IDLE:
  - proto_err=1 and stays 1 until rst.
  - No ack generated.
